fir_delay_line: RTL and testbench
=================================

# fir_delay_line

Parametrised, multi-channel successor to the single-channel FIR input shift register. Accepts a time-interleaved sample stream through a valid/ready handshake and keeps one NUM_TAPS-deep delay line per channel. After each accepted sample it presents a registered parallel tap vector for that sample's channel. It also tracks fill level, so the downstream MAC array knows when a channel's window holds only real samples.

## Interface
- DATA_WIDTH, 16, sample width in bits
- NUM_TAPS, 8, delay-line depth per channel (≥2)
- NUM_CH, 1, number of interleaved channels (≥1)
- CH_W, derived, max(1, $clog2(NUM_CH))

- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a sample
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_WIDTH  sample for channel in_ch
- in_ch  out  CH_W  channel the next accepted sample is written to
- out_valid  out  1  tap vector valid
- out_ready  in  1  downstream consumes tap vector
- out_ch  out  CH_W  channel of presented taps
- out_taps  out  NUM_TAPS×DATA_WIDTH  out_taps[0] newest … out_taps[NUM_TAPS-1] oldest
- out_primed  out  1  presented channel's line fully filled since reset/flush
- flush  in  1  present only with FIR_DL_FLUSH_EN

## Operation
- Accept = in_valid && in_ready. in_ready = !rst && (!out_valid || out_ready).
- On accept:
  - shift line[in_ch]: tap[i] ← tap[i-1] for i = NUM_TAPS-1 down to 1; tap[0] ← in_data.
  - Other channels' lines are unchanged.
- Channel pointer in_ch advances by one per accept and wraps NUM_CH-1 → 0. With NUM_CH=1 it is constant 0.
- Output register, loaded on accept:
  - out_taps = the post-shift contents of line[in_ch].
  - out_ch = in_ch.
  - out_valid ← 1.
- If there is no accept and out_ready=1, out_valid ← 0.
- While out_valid && !out_ready:
  - out_taps, out_ch and out_primed are held stable.
  - in_ready = 0.
- Fill counter per channel: width $clog2(NUM_TAPS+1). It increments on an accept to that channel and saturates at NUM_TAPS.
- out_primed is registered with the taps. It is 1 when the post-increment count of that channel equals NUM_TAPS.
- Data is passed unmodified; no arithmetic is performed on samples.

## Timing
- Reset values:
  - all lines, counters, in_ch, out_ch, out_taps, out_primed = 0.
  - out_valid = 0.
  - in_ready = 0 while rst is high and 1 the cycle after.
- Latency: sample accepted at edge k appears in out_taps[0] with out_valid=1 after edge k (visible cycle k+1).
- Throughput: 1 sample/cycle when out_ready is held high.
- Accept and consume in the same cycle: the output register reloads and out_valid stays 1.
- rst mid-stream:
  - the in-flight output is discarded; out_valid=0 the next cycle.
  - all channels are unprimed.
  - in_ch returns to 0.

## Configuration
- FIR_DL_FLUSH_EN defined: the flush port exists. A flush cycle has the same effect as rst on lines, counters, in_ch and out_valid:
  - in_ready = 0 during flush.
  - a sample offered that cycle is not accepted.
  - flush has priority over out_ready and in_valid.
- Undefined: no flush port and no flush logic. Only rst clears state.

## Structure
- Shared package fir_pkg:
  - DATA_WIDTH default.
  - typedef sample_t (logic [DATA_WIDTH-1:0]).
  - typedef tap_vec_t (sample_t array [NUM_TAPS]).
- Natural sub-module fir_dl_channel:
  - one channel's shift line plus fill counter.
  - ports: clk, rst, clr, shift_en, din, taps, primed.
- Top level instantiates NUM_CH copies. It holds the channel pointer, the handshake and the output register, with an out_taps mux by in_ch.

## Test plan
- Reset, NUM_CH=1, NUM_TAPS=4, out_ready=1, feed 1,2,3,4,5 back-to-back -> out_valid every cycle from cycle 1; final out_taps = {5,4,3,2}; out_primed first 1 on sample 4.
- NUM_CH=2, feed 10,20,11,21,12,22 -> out_ch alternates 0,1; after 12: ch0 taps[0..2] = 12,11,10; after 22: ch1 taps[0..2] = 22,21,20.
- out_ready=0 for 3 cycles after sample 1 with in_valid=1 -> in_ready=0; out_taps held; sample 2 accepted only on the cycle out_ready returns to 1, with no loss or duplication.
- rst asserted between samples 3 and 4 -> out_valid=0; in_ch=0; next sample gives out_taps = {s,0,0,0} and out_primed=0.
- FIR_DL_FLUSH_EN: flush and in_valid in the same cycle -> sample not accepted; next accepted sample gives all-zero older taps and in_ch=0.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the multi-channel FIR delay line.
//   DEF_DATA_WIDTH / DEF_NUM_TAPS : default sample width and line depth
//   sample_t / tap_vec_t          : sample and tap-vector types at the defaults
//   ch_width()                    : channel-pointer width, never below 1 bit
package fir_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_NUM_TAPS   = 8;

   typedef logic [DEF_DATA_WIDTH-1:0] sample_t;
   typedef sample_t tap_vec_t [DEF_NUM_TAPS];

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_dl_channel.sv
// fir_dl_channel: one channel's shift line plus saturating fill counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (same effect as rst)
//   shift_en  : shift din into tap 0 this cycle
//   din       : incoming sample
//   taps      : line contents as they will be after this cycle's shift
//               (tap i at [i*DATA_WIDTH +: DATA_WIDTH], tap 0 newest)
//   primed    : fill count after this cycle's shift equals NUM_TAPS
// taps/primed are look-ahead views so the top can register them together
// with the sample that caused the shift.
module fir_dl_channel
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_TAPS   = DEF_NUM_TAPS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           shift_en,
   input  logic [DATA_WIDTH-1:0]          din,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] taps,
   output logic                           primed
);

   localparam int CW = $clog2(NUM_TAPS + 1);

   logic [DATA_WIDTH-1:0] line_q [NUM_TAPS];
   logic [DATA_WIDTH-1:0] line_d [NUM_TAPS];
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         cnt_d;

   always_comb begin
      line_d = line_q;
      if (shift_en) begin
         line_d[0] = din;
         for (int i = 1; i < NUM_TAPS; i++) begin
            line_d[i] = line_q[i-1];
         end
      end
   end

   // Counter saturates so it only ever answers "is the window full of real samples".
   always_comb begin
      cnt_d = cnt_q;
      if (shift_en && (cnt_q != CW'(NUM_TAPS))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            line_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar i = 0; i < NUM_TAPS; i++) begin : g_taps
      assign taps[i*DATA_WIDTH +: DATA_WIDTH] = line_d[i];
   end

   assign primed = (cnt_d == CW'(NUM_TAPS));

endmodule

// File: rtl/fir_delay_line.sv
// fir_delay_line: multi-channel FIR input delay line with registered tap output.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid / in_ready / in_data : sample input; in_ch names the channel the
//                next accepted sample is written to (round-robin)
//   out_valid / out_ready         : tap-vector output handshake
//   out_ch, out_taps, out_primed  : channel, taps (tap 0 newest, at LSBs) and
//                "window holds only real samples" for the presented vector
//   flush      : only with FIR_DL_FLUSH_EN defined; clears lines, counters,
//                channel pointer and out_valid like rst
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// output register accepts a new sample whenever it is empty or being consumed
// in the same cycle, so in_ready = !rst && !flush && (!out_valid || out_ready);
// while out_valid && !out_ready the output is held and nothing is accepted.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_TAPS   = DEF_NUM_TAPS,
   parameter int NUM_CH     = 1,
   parameter int CH_W       = ch_width(NUM_CH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_data,
   output logic [CH_W-1:0]                in_ch,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CH_W-1:0]                out_ch,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps,
   output logic                           out_primed
`ifdef FIR_DL_FLUSH_EN
   ,
   input  logic                           flush
`endif
);

   localparam int TW = NUM_TAPS * DATA_WIDTH;

   logic              clr;
   logic              accept;
   logic [TW-1:0]     ch_taps [NUM_CH];
   logic [NUM_CH-1:0] ch_primed;
   logic [TW-1:0]     sel_taps;
   logic              sel_primed;

`ifdef FIR_DL_FLUSH_EN
   assign clr = flush;
`else
   assign clr = 1'b0;
`endif

   assign in_ready = !rst && !clr && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fir_dl_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_TAPS   (NUM_TAPS)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .shift_en (accept && (in_ch == CH_W'(c))),
         .din      (in_data),
         .taps     (ch_taps[c]),
         .primed   (ch_primed[c])
      );
   end

   // Compare-based select keeps the mux safe when NUM_CH is not a power of two.
   always_comb begin
      sel_taps   = '0;
      sel_primed = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_ch == CH_W'(c)) begin
            sel_taps   = ch_taps[c];
            sel_primed = ch_primed[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         in_ch <= '0;
      end else if (accept) begin
         in_ch <= (in_ch == CH_W'(NUM_CH - 1)) ? '0 : in_ch + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_taps   <= '0;
         out_primed <= 1'b0;
      end else if (clr) begin
         out_valid  <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_ch     <= in_ch;
         out_taps   <= sel_taps;
         out_primed <= sel_primed;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_delay_line.sv
module tb_fir_delay_line;

   localparam int DW = 16;
   localparam int NT = 4;

   logic clk;
   logic rst;
   logic flush;

   // DUT A: single channel; DUT B: two interleaved channels
   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_primed;
   logic [DW-1:0] a_in_data;
   logic [0:0]    a_in_ch, a_out_ch;
   logic [NT*DW-1:0] a_out_taps;
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_primed;
   logic [DW-1:0] b_in_data;
   logic [0:0]    b_in_ch, b_out_ch;
   logic [NT*DW-1:0] b_out_taps;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: full sample history per channel since the last clear
   int            sel;
   int            m_nch;
   logic [DW-1:0] m_hist [2][$];
   int            m_ptr;
   logic          m_ov;
   logic [0:0]    m_och;
   logic [NT*DW-1:0] m_taps;
   logic          m_primed;

   fir_delay_line #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .NUM_CH(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_ch(a_in_ch), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_ch(a_out_ch), .out_taps(a_out_taps),
      .out_primed(a_out_primed)
`ifdef FIR_DL_FLUSH_EN
      , .flush(flush)
`endif
   );

   fir_delay_line #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .NUM_CH(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_ch(b_in_ch), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_ch(b_out_ch), .out_taps(b_out_taps),
      .out_primed(b_out_primed)
`ifdef FIR_DL_FLUSH_EN
      , .flush(flush)
`endif
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int c = 0; c < 2; c++) m_hist[c].delete();
      m_ptr = 0;
      m_ov  = 1'b0;
   endtask

   // One clock cycle on the selected DUT; checks in_ready before the edge and
   // all outputs after it against the model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy);
      logic rdy, exp_rdy, acc, r, f, ov, pr;
      logic [0:0] och, ich;
      logic [NT*DW-1:0] taps;
      int n;
      if (sel == 0) begin
         a_in_valid = v; a_in_data = d; a_out_ready = ordy;
      end else begin
         b_in_valid = v; b_in_data = d; b_out_ready = ordy;
      end
      @(negedge clk);
      r = rst;
      f = flush;
      rdy = (sel == 0) ? a_in_ready : b_in_ready;
      exp_rdy = !r && !f && (!m_ov || ordy);
      n_checks++;
      if (rdy !== exp_rdy) $display("FAIL in_ready: got %b expected %b", rdy, exp_rdy);
      else n_pass++;
      acc = v && exp_rdy;
      @(posedge clk);
      #1;
      if (r) begin
         model_clear();
         m_och = '0; m_taps = '0; m_primed = 1'b0;
      end else if (f) begin
         model_clear();
      end else if (acc) begin
         m_hist[m_ptr].push_back(d);
         n = m_hist[m_ptr].size();
         m_taps = '0;
         for (int i = 0; i < NT; i++)
            if (i < n) m_taps[i*DW +: DW] = m_hist[m_ptr][n-1-i];
         m_primed = (n >= NT);
         m_och = m_ptr[0:0];
         m_ov = 1'b1;
         m_ptr = (m_ptr + 1) % m_nch;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      ov   = (sel == 0) ? a_out_valid  : b_out_valid;
      och  = (sel == 0) ? a_out_ch     : b_out_ch;
      ich  = (sel == 0) ? a_in_ch      : b_in_ch;
      taps = (sel == 0) ? a_out_taps   : b_out_taps;
      pr   = (sel == 0) ? a_out_primed : b_out_primed;
      n_checks++;
      if (ov !== m_ov) $display("FAIL out_valid: got %b expected %b", ov, m_ov);
      else n_pass++;
      n_checks++;
      if (ich !== m_ptr[0:0]) $display("FAIL in_ch: got %0d expected %0d", ich, m_ptr);
      else n_pass++;
      if (m_ov) begin
         n_checks++;
         if (taps !== m_taps || och !== m_och || pr !== m_primed)
            $display("FAIL out_reg: got taps=%h ch=%0d primed=%b expected taps=%h ch=%0d primed=%b",
                     taps, och, pr, m_taps, m_och, m_primed);
         else n_pass++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, '0, 1'b1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      sel = 0; m_nch = 1;
      rst = 1'b1;
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({a_out_valid, a_out_ch, a_out_taps, a_out_primed, a_in_ch} !== '0 ||
          {b_out_valid, b_out_ch, b_out_taps, b_out_primed, b_in_ch} !== '0)
         $display("FAIL reset_values: got a=%h b=%h expected 0",
                  {a_out_valid, a_out_ch, a_out_taps, a_out_primed, a_in_ch},
                  {b_out_valid, b_out_ch, b_out_taps, b_out_primed, b_in_ch});
      else n_pass++;
      n_checks++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
         $display("FAIL ready_after_reset: got %b%b expected 11", a_in_ready, b_in_ready);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      sel = 0; m_nch = 1;
      do_reset();
      for (int s = 1; s <= 5; s++) begin
         step(1'b1, DW'(s), 1'b1);
         n_checks++;
         if (a_out_primed !== (s >= 4)) $display("FAIL primed_sample_%0d: got %b expected %b", s, a_out_primed, s >= 4);
         else n_pass++;
      end
      n_checks++;
      if (a_out_taps !== 64'h0002_0003_0004_0005) $display("FAIL final_taps: got %h expected %h", a_out_taps, 64'h0002_0003_0004_0005);
      else n_pass++;
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_interleave();
      logic [DW-1:0] seq [6];
      seq = '{16'd10, 16'd20, 16'd11, 16'd21, 16'd12, 16'd22};
      sel = 1; m_nch = 2;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, seq[i], 1'b1);
         n_checks++;
         if (b_out_ch !== 1'(i % 2)) $display("FAIL interleave_ch_%0d: got %0d expected %0d", i, b_out_ch, i % 2);
         else n_pass++;
         if (i == 4) begin
            n_checks++;
            if (b_out_taps[47:0] !== 48'h000a_000b_000c) $display("FAIL ch0_taps: got %h expected %h", b_out_taps[47:0], 48'h000a_000b_000c);
            else n_pass++;
         end
         if (i == 5) begin
            n_checks++;
            if (b_out_taps[47:0] !== 48'h0014_0015_0016) $display("FAIL ch1_taps: got %h expected %h", b_out_taps[47:0], 48'h0014_0015_0016);
            else n_pass++;
         end
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_backpressure();
      sel = 0; m_nch = 1;
      do_reset();
      step(1'b1, 16'd1, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 16'd2, 1'b0);
      step(1'b1, 16'd2, 1'b1);
      n_checks++;
      if (a_out_taps[31:0] !== 32'h0001_0002) $display("FAIL stall_taps: got %h expected %h", a_out_taps[31:0], 32'h0001_0002);
      else n_pass++;
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_rst_mid();
      sel = 0; m_nch = 1;
      do_reset();
      for (int s = 1; s <= 3; s++) step(1'b1, DW'(s), 1'b1);
      do_reset();
      step(1'b1, 16'h0077, 1'b1);
      n_checks++;
      if (a_out_taps !== 64'h77 || a_out_primed !== 1'b0)
         $display("FAIL after_rst: got taps=%h primed=%b expected taps=%h primed=0", a_out_taps, a_out_primed, 64'h77);
      else n_pass++;
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_random();
      sel = 1; m_nch = 2;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         rst = ($urandom_range(0, 49) == 0);
         step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0);
      end
      rst = 1'b0;
      step(1'b0, '0, 1'b1);
   endtask

`ifdef FIR_DL_FLUSH_EN
   task automatic test_flush();
      sel = 1; m_nch = 2;
      do_reset();
      for (int s = 5; s <= 7; s++) step(1'b1, DW'(s), 1'b1);
      flush = 1'b1;
      step(1'b1, 16'd9, 1'b1);
      flush = 1'b0;
      step(1'b1, 16'd8, 1'b1);
      n_checks++;
      if (b_out_taps !== 64'h8 || b_out_ch !== 1'b0)
         $display("FAIL after_flush: got taps=%h ch=%0d expected taps=%h ch=0", b_out_taps, b_out_ch, 64'h8);
      else n_pass++;
      step(1'b0, '0, 1'b1);
   endtask
`endif

   initial begin
      rst = 1'b1; flush = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      model_clear();
      m_och = '0; m_taps = '0; m_primed = 1'b0;
      test_reset();
      test_back_to_back();
      test_interleave();
      test_backpressure();
      test_rst_mid();
      test_random();
`ifdef FIR_DL_FLUSH_EN
      test_flush();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
